// File: rtl/btn_debounce_pkg.sv
// -----------------------------------------------------------------------------
// btn_debounce_pkg
//   Board-level constants for the Papilio push-button/switch conditioning path,
//   plus the counter-width helper shared by the prescaler and the per-channel
//   stability counters.
//
//   CLK_HZ               : system clock frequency driving btn_debounce.
//   SAMPLE_HZ            : target sample-tick rate (1 kHz -> 1 ms ticks).
//   DEFAULT_TICK_DIV     : clk cycles per sample tick at CLK_HZ.
//   DEFAULT_STABLE_TICKS : consecutive mismatching ticks to accept a new level.
//   DEFAULT_CHANNELS     : a, b, s lines.
// -----------------------------------------------------------------------------
package btn_debounce_pkg;

    localparam int CLK_HZ               = 32_000_000;
    localparam int SAMPLE_HZ            = 1_000;
    localparam int DEFAULT_TICK_DIV     = CLK_HZ / SAMPLE_HZ;
    localparam int DEFAULT_STABLE_TICKS = 16;
    localparam int DEFAULT_CHANNELS     = 3;

    // Width of a counter that must hold 0..n-1. Never returns 0 so that the
    // degenerate n==1 case still gets a real (constant-zero) register.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// -----------------------------------------------------------------------------
// btn_debounce_chan
//   One debounced input line: two-flop synchroniser, tick-driven stability
//   counter, registered level and single-cycle rise/fall pulses.
//
//   Ports
//     clk      in   system clock, all state on rising edge
//     reset    in   asynchronous active-low reset
//     tick_i   in   shared combinational sample tick from the prescaler
//     btn_i    in   raw asynchronous input line
//     level_o  out  debounced level (registered)
//     rise_o   out  one-clk pulse on the first cycle of level_o==1
//     fall_o   out  one-clk pulse on the first cycle of level_o==0
// -----------------------------------------------------------------------------
module btn_debounce_chan
    import btn_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

    // Synchroniser: meta_q may go metastable; nothing but sync_q reads it.
    logic          meta_q;
    logic          sync_q;

    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          rise_q,  rise_d;
    logic          fall_q,  fall_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
        end
    end

    // The match check is evaluated first, so an input that flips back on the
    // accepting tick simply clears the count instead of changing the level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_q == level_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                level_d = sync_q;
                rise_d  = sync_q;
                fall_d  = ~sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Input conditioning for the board push-buttons/switches feeding the
//   registered logic stages. A single shared prescaler produces the sample
//   tick; each line gets its own synchroniser and stability counter.
//
//   Parameters
//     CHANNELS     number of independent lines (>= 1)
//     TICK_DIV     clk cycles per sample tick (>= 1; 1 means every cycle)
//     STABLE_TICKS consecutive mismatching ticks to accept a level (>= 1)
//
//   Ports
//     clk      in   system clock
//     reset    in   asynchronous active-low reset
//     btn_i    in   raw asynchronous inputs  [CHANNELS]
//     level_o  out  debounced levels         [CHANNELS]
//     rise_o   out  0->1 pulses              [CHANNELS]
//     fall_o   out  1->0 pulses              [CHANNELS]
//     tick_o   out  registered sample-tick strobe
// -----------------------------------------------------------------------------
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int CHANNELS     = DEFAULT_CHANNELS,
    parameter int TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic                tick_o
);

    localparam int            PW       = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_c;
    logic          tick_q;

    // With TICK_DIV==1 pre_q is pinned at 0 == PRE_LAST, so tick_c is
    // permanently high and the channels sample every cycle.
    assign tick_c = (pre_q == PRE_LAST);
    assign pre_d  = tick_c ? '0 : pre_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_c;
        end
    end

    assign tick_o = tick_q;

    // Channels use the combinational tick so acceptance lines up with the
    // prescaler wrap rather than one cycle later.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        btn_debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .tick_i  (tick_c),
            .btn_i   (btn_i[g]),
            .level_o (level_o[g]),
            .rise_o  (rise_o[g]),
            .fall_o  (fall_o[g])
        );
    end

endmodule
